ntt_job_scheduler: RTL and testbench
====================================

Name: ntt_job_scheduler

Overview:
- Shares one NTT engine (NTT controller, butterfly, ping-pong BRAM banks, twiddle ROM) between NUM_REQ requesters, e.g. Kyber/Dilithium keygen, encaps and sign paths.
- Round-robin arbitrates job requests and sequences each job through three phases: requester load, engine run, requester unload.
- Drives the engine's enable/mode/reset and the BRAM ownership mux select; provides a watchdog abort.

Parameters:
- NUM_REQ, 4, number of requesters (>=2).
- TIMEOUT, 4096, max cycles in RUN before abort.
- CNT_W, $clog2(TIMEOUT+1), watchdog counter width.
- IDW, $clog2(NUM_REQ), owner index width.

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous, active-low reset.
- req  in  NUM_REQ  per-requester job request; level, held until job_done/job_err.
- req_mode  in  NUM_REQ  per-requester mode: 0 = NTT, 1 = INTT.
- gnt  out  NUM_REQ  one-hot grant, held from LOAD through UNLOAD.
- owner_id  out  IDW  index of granted requester; valid while busy.
- load_done  in  1  granted requester has finished writing the coefficients.
- unload_done  in  1  granted requester has finished reading the result.
- job_done  out  NUM_REQ  1-cycle completion pulse to the owner.
- job_err  out  NUM_REQ  1-cycle abort pulse to the owner.
- bram_owner  out  2  BRAM mux select: 0 none, 1 requester, 2 engine.
- ntt_enable  out  1  1-cycle start pulse to the engine.
- ntt_mode  out  1  mode to the engine; stable from START through RUN.
- ntt_rst  out  1  active-high engine reset.
- ntt_done  in  1  engine completion pulse.
- busy  out  1  high in any state except IDLE.

Behaviour:
- Reset (rst=0 at clk edge): state IDLE; gnt, job_done, job_err, ntt_enable, ntt_mode = 0; owner_id = 0; bram_owner = 0; busy = 0; rr pointer = 0; watchdog = 0; ntt_rst = 1.
- ntt_rst: forced to 1 while rst=0; drops to 0 on the first edge with rst=1. Otherwise 1 only for the single ABORT cycle.
- All outputs are registered.
- States: IDLE, LOAD, START, RUN, UNLOAD, ABORT.
- IDLE:
  - If any req bit is high, pick the lowest index at or after (last_owner+1) mod NUM_REQ.
  - Next cycle: state LOAD, gnt one-hot, owner_id set, bram_owner = 1, mode latched from req_mode[owner].
  - Latency req->gnt is 1 cycle.
- LOAD:
  - On load_done: go to START; bram_owner = 2.
  - If req[owner] drops before load_done: cancel. Go to IDLE, clear gnt, no pulses; the pointer still advances.
  - If load_done and the req drop occur in the same cycle, load_done wins.
- START:
  - ntt_enable = 1 for exactly 1 cycle; ntt_mode = latched mode.
  - Watchdog cleared. Next state RUN.
- RUN:
  - Watchdog increments each cycle. req changes are ignored.
  - On ntt_done: go to UNLOAD, bram_owner = 1.
  - Else if watchdog reaches TIMEOUT-1: go to ABORT.
  - ntt_done in the same cycle as the timeout: done wins.
- UNLOAD:
  - On unload_done: job_done[owner] pulses 1 cycle; gnt = 0, bram_owner = 0; go to IDLE.
  - ntt_done to job_done takes >= 2 cycles.
- ABORT (1 cycle):
  - ntt_rst = 1, job_err[owner] = 1; gnt = 0, bram_owner = 0.
  - Next state IDLE.
- Arbitration:
  - last_owner updates at every grant.
  - Requests arriving while busy wait; no request is lost while held high.
  - Back-to-back jobs: IDLE is always visited for 1 cycle between jobs.
- ntt_done or load_done seen in an unexpected state: ignored.
- Reset mid-job: immediate return to IDLE with the reset values above. The engine is held in reset via ntt_rst.

Decomposition:
- ntt_pkg: sched_state_t enum, bram_owner_t enum (OWN_NONE, OWN_REQ, OWN_ENG), MODE_NTT/MODE_INTT constants.
- Sub-module rr_arbiter (NUM_REQ): combinational pick from the req vector and the pointer. The scheduler registers the result.

Test Plan:
- Single job: req=4'b0001, mode=1; load_done at t+5 -> ntt_enable one pulse with ntt_mode=1; ntt_done at t+40; unload_done at t+45 -> job_done=4'b0001 one cycle; bram_owner sequence 1,2,1,0.
- Fairness: req=4'b1111 held, engine completes each job -> grant order 0,1,2,3,0; each gnt one-hot; one IDLE cycle between jobs.
- Timeout: TIMEOUT=16, ntt_done never asserted -> 16 cycles after ntt_enable, ntt_rst=1 and job_err[owner]=1 for one cycle; state IDLE; next req is granted normally.
- Collision: ntt_done on the same cycle the watchdog hits TIMEOUT-1 -> UNLOAD, no job_err, no ntt_rst pulse.
- Cancel: req[2] drops during LOAD -> gnt cleared next cycle, no ntt_enable, no job_done/job_err; next grant goes to requester 3 if it is requesting.
- Reset: rst=0 during RUN -> all outputs at reset values next edge, ntt_rst=1; after release, ntt_rst=0 and a fresh req is granted in 1 cycle starting from requester 0.

Source files
------------

// File: rtl/ntt_pkg.sv
// Shared types and constants for the NTT job scheduler and its arbiter.
package ntt_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_START,
        S_RUN,
        S_UNLOAD,
        S_ABORT
    } sched_state_t;

    typedef enum logic [1:0] {
        OWN_NONE = 2'd0,
        OWN_REQ  = 2'd1,
        OWN_ENG  = 2'd2
    } bram_owner_t;

    localparam logic MODE_NTT  = 1'b0;
    localparam logic MODE_INTT = 1'b1;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin pick: lowest requesting index at or after ptr, wrapping.
module rr_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int IDW     = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [IDW-1:0]     ptr,
    output logic               valid,
    output logic [IDW-1:0]     pick
);

    logic [IDW-1:0]     cand_idx [NUM_REQ];
    logic [NUM_REQ-1:0] cand_hit;

    // cand_idx[k] is the requester seen k places after the pointer
    genvar gi;
    generate
        for (gi = 0; gi < NUM_REQ; gi++) begin : g_cand
            assign cand_idx[gi] = IDW'((32'(ptr) + gi) % NUM_REQ);
            assign cand_hit[gi] = req[cand_idx[gi]];
        end
    endgenerate

    always_comb begin
        valid = |cand_hit;
        pick  = ptr;
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            if (cand_hit[i]) begin
                pick = cand_idx[i];
            end
        end
    end

endmodule

// File: rtl/ntt_job_scheduler.sv
// Shares one NTT engine between NUM_REQ requesters: round-robin grant, then
// load / engine run / unload phases with a watchdog abort on a stuck engine.
module ntt_job_scheduler
    import ntt_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int TIMEOUT = 4096,
    parameter int CNT_W   = $clog2(TIMEOUT + 1),
    parameter int IDW     = $clog2(NUM_REQ)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [NUM_REQ-1:0] req,
    input  logic [NUM_REQ-1:0] req_mode,
    output logic [NUM_REQ-1:0] gnt,
    output logic [IDW-1:0]     owner_id,
    input  logic               load_done,
    input  logic               unload_done,
    output logic [NUM_REQ-1:0] job_done,
    output logic [NUM_REQ-1:0] job_err,
    output logic [1:0]         bram_owner,
    output logic               ntt_enable,
    output logic               ntt_mode,
    output logic               ntt_rst,
    input  logic               ntt_done,
    output logic               busy
);

    sched_state_t       state_reg;
    bram_owner_t        bram_reg;
    logic [NUM_REQ-1:0] gnt_reg;
    logic [IDW-1:0]     owner_reg;
    logic [IDW-1:0]     ptr_reg;
    logic [CNT_W-1:0]   wdog_reg;
    logic               mode_reg;
    logic               ntt_enable_reg;
    logic               ntt_mode_reg;
    logic               ntt_rst_reg;
    logic [NUM_REQ-1:0] job_done_reg;
    logic [NUM_REQ-1:0] job_err_reg;
    logic               busy_reg;

    logic               arb_valid;
    logic [IDW-1:0]     arb_pick;
    logic [IDW-1:0]     ptr_next;
    logic [NUM_REQ-1:0] pick_oh;
    logic [NUM_REQ-1:0] owner_oh;

    rr_arbiter #(
        .NUM_REQ (NUM_REQ),
        .IDW     (IDW)
    ) u_arb (
        .req   (req),
        .ptr   (ptr_reg),
        .valid (arb_valid),
        .pick  (arb_pick)
    );

    assign pick_oh  = {{(NUM_REQ-1){1'b0}}, 1'b1} << arb_pick;
    assign owner_oh = {{(NUM_REQ-1){1'b0}}, 1'b1} << owner_reg;
    assign ptr_next = (arb_pick == IDW'(NUM_REQ - 1)) ? '0 : arb_pick + IDW'(1);

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_reg      <= S_IDLE;
            bram_reg       <= OWN_NONE;
            gnt_reg        <= '0;
            owner_reg      <= '0;
            ptr_reg        <= '0;
            wdog_reg       <= '0;
            mode_reg       <= MODE_NTT;
            ntt_enable_reg <= 1'b0;
            ntt_mode_reg   <= MODE_NTT;
            ntt_rst_reg    <= 1'b1;
            job_done_reg   <= '0;
            job_err_reg    <= '0;
            busy_reg       <= 1'b0;
        end else begin
            // single-cycle strobes fall back unless re-armed below
            ntt_enable_reg <= 1'b0;
            ntt_rst_reg    <= 1'b0;
            job_done_reg   <= '0;
            job_err_reg    <= '0;
            case (state_reg)
                S_IDLE: begin
                    if (arb_valid) begin
                        state_reg <= S_LOAD;
                        gnt_reg   <= pick_oh;
                        owner_reg <= arb_pick;
                        ptr_reg   <= ptr_next;
                        mode_reg  <= req_mode[arb_pick];
                        bram_reg  <= OWN_REQ;
                        busy_reg  <= 1'b1;
                    end
                end
                S_LOAD: begin
                    if (load_done) begin
                        state_reg      <= S_START;
                        bram_reg       <= OWN_ENG;
                        ntt_enable_reg <= 1'b1;
                        ntt_mode_reg   <= mode_reg;
                    end else if (!req[owner_reg]) begin
                        state_reg <= S_IDLE;
                        gnt_reg   <= '0;
                        bram_reg  <= OWN_NONE;
                        busy_reg  <= 1'b0;
                    end
                end
                S_START: begin
                    state_reg <= S_RUN;
                    wdog_reg  <= '0;
                end
                S_RUN: begin
                    // engine completion beats a watchdog expiry in the same cycle
                    if (ntt_done) begin
                        state_reg <= S_UNLOAD;
                        bram_reg  <= OWN_REQ;
                    end else if (wdog_reg == CNT_W'(TIMEOUT - 1)) begin
                        state_reg   <= S_ABORT;
                        ntt_rst_reg <= 1'b1;
                        job_err_reg <= owner_oh;
                        gnt_reg     <= '0;
                        bram_reg    <= OWN_NONE;
                    end else begin
                        wdog_reg <= wdog_reg + CNT_W'(1);
                    end
                end
                S_UNLOAD: begin
                    if (unload_done) begin
                        state_reg    <= S_IDLE;
                        job_done_reg <= owner_oh;
                        gnt_reg      <= '0;
                        bram_reg     <= OWN_NONE;
                        busy_reg     <= 1'b0;
                    end
                end
                S_ABORT: begin
                    state_reg <= S_IDLE;
                    busy_reg  <= 1'b0;
                end
                default: begin
                    state_reg <= S_IDLE;
                    gnt_reg   <= '0;
                    bram_reg  <= OWN_NONE;
                    busy_reg  <= 1'b0;
                end
            endcase
        end
    end

    assign gnt        = gnt_reg;
    assign owner_id   = owner_reg;
    assign job_done   = job_done_reg;
    assign job_err    = job_err_reg;
    assign bram_owner = bram_reg;
    assign ntt_enable = ntt_enable_reg;
    assign ntt_mode   = ntt_mode_reg;
    assign ntt_rst    = ntt_rst_reg;
    assign busy       = busy_reg;

endmodule

// File: tb/tb_ntt_job_scheduler.sv
// Directed bench for ntt_job_scheduler: a job table for grant order/outcomes
// plus hand sequences for reset, cancel and reset-during-run.
module tb_ntt_job_scheduler;

    localparam int ENG_DONE = 0;
    localparam int ENG_TMO  = 1;
    localparam int ENG_COLL = 2;
    localparam int NVEC     = 10;

    typedef struct {
        logic [3:0] req;
        logic [3:0] mode;
        int         eng;
        int         load_dly;
        int         done_dly;
        int         exp_owner;
        logic       exp_mode;
    } vec_t;

    logic       clk;
    logic       rst;
    logic [3:0] req;
    logic [3:0] req_mode;
    logic [3:0] gnt;
    logic [1:0] owner_id;
    logic       load_done;
    logic       unload_done;
    logic [3:0] job_done;
    logic [3:0] job_err;
    logic [1:0] bram_owner;
    logic       ntt_enable;
    logic       ntt_mode;
    logic       ntt_rst;
    logic       ntt_done;
    logic       busy;

    int n_tests = 0;
    int n_fail  = 0;

    vec_t vecs [NVEC];

    ntt_job_scheduler #(
        .NUM_REQ (4),
        .TIMEOUT (16)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .req         (req),
        .req_mode    (req_mode),
        .gnt         (gnt),
        .owner_id    (owner_id),
        .load_done   (load_done),
        .unload_done (unload_done),
        .job_done    (job_done),
        .job_err     (job_err),
        .bram_owner  (bram_owner),
        .ntt_enable  (ntt_enable),
        .ntt_mode    (ntt_mode),
        .ntt_rst     (ntt_rst),
        .ntt_done    (ntt_done),
        .busy        (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic vec_t mk(input logic [3:0] r, input logic [3:0] m, input int e,
                                input int ld, input int dd, input int own, input logic md);
        vec_t v;
        v.req = r; v.mode = m; v.eng = e; v.load_dly = ld; v.done_dly = dd;
        v.exp_owner = own; v.exp_mode = md;
        return v;
    endfunction

    // Runs one job from an IDLE sample point and ends on the following IDLE sample.
    task automatic run_job(input int idx, input vec_t v);
        logic [3:0] oh;
        int         lat;
        int         cyc;
        string      outcome;
        oh = 4'b0001 << v.exp_owner;
        req      = v.req;
        req_mode = v.mode;
        lat = 0;
        do begin
            step();
            lat++;
        end while (gnt == 4'b0000 && lat < 20);
        check("gnt_latency", lat, 1);
        check("gnt_onehot", gnt, oh);
        check("owner_id", owner_id, v.exp_owner);
        check("bram_owner_load", bram_owner, 1);
        check("busy_load", busy, 1);
        check("job_done_cleared", job_done, 0);
        repeat (v.load_dly) step();
        check("gnt_held_load", gnt, oh);
        load_done = 1'b1;
        step();
        load_done = 1'b0;
        check("ntt_enable_start", ntt_enable, 1);
        check("ntt_mode", ntt_mode, v.exp_mode);
        check("bram_owner_eng", bram_owner, 2);
        step();
        check("ntt_enable_pulse", ntt_enable, 0);
        if (v.eng == ENG_TMO) begin
            // 16 RUN cycles follow the START cycle, ABORT is the 17th sample after it
            cyc = 1;
            while (job_err == 4'b0000 && cyc < 40) begin
                step();
                cyc++;
            end
            check("timeout_cycles", cyc, 17);
            check("job_err_abort", job_err, oh);
            check("ntt_rst_abort", ntt_rst, 1);
            check("gnt_abort", gnt, 0);
            check("bram_owner_abort", bram_owner, 0);
            step();
            check("job_err_pulse", job_err, 0);
            check("ntt_rst_release", ntt_rst, 0);
            check("busy_after_abort", busy, 0);
            outcome = "abort";
        end else begin
            if (v.eng == ENG_COLL) repeat (15) step();
            else repeat (v.done_dly) step();
            ntt_done = 1'b1;
            step();
            ntt_done = 1'b0;
            check("bram_owner_unload", bram_owner, 1);
            check("job_err_none", job_err, 0);
            check("ntt_rst_none", ntt_rst, 0);
            check("gnt_held_unload", gnt, oh);
            step();
            step();
            unload_done = 1'b1;
            step();
            unload_done = 1'b0;
            check("job_done", job_done, oh);
            check("job_err_done", job_err, 0);
            check("gnt_released", gnt, 0);
            check("bram_owner_idle", bram_owner, 0);
            check("busy_idle", busy, 0);
            outcome = (v.eng == ENG_COLL) ? "collision-done" : "done";
        end
        $display("[TB] job %0d req=%b owner=%0d gnt=%b mode=%0d outcome=%s",
                 idx, v.req, owner_id, oh, ntt_mode, outcome);
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL global_timeout: got running expected finished");
        $fatal(1, "bench did not finish");
    end

    initial begin
        rst = 1'b0; req = '0; req_mode = '0;
        load_done = 1'b0; unload_done = 1'b0; ntt_done = 1'b0;

        // rows after reset: pointer starts at 0, advances past each winner
        vecs[0] = mk(4'b1111, 4'b1010, ENG_DONE, 1, 3,  0, 1'b0);
        vecs[1] = mk(4'b1111, 4'b1010, ENG_DONE, 0, 0,  1, 1'b1);
        vecs[2] = mk(4'b1111, 4'b1010, ENG_DONE, 2, 5,  2, 1'b0);
        vecs[3] = mk(4'b1111, 4'b1010, ENG_DONE, 0, 1,  3, 1'b1);
        vecs[4] = mk(4'b1111, 4'b1010, ENG_DONE, 0, 2,  0, 1'b0);
        vecs[5] = mk(4'b0001, 4'b0001, ENG_DONE, 4, 10, 0, 1'b1);
        vecs[6] = mk(4'b0100, 4'b0100, ENG_TMO,  0, 0,  2, 1'b1);
        vecs[7] = mk(4'b0110, 4'b0000, ENG_COLL, 1, 0,  1, 1'b0);
        vecs[8] = mk(4'b1001, 4'b1000, ENG_DONE, 0, 3,  3, 1'b1);
        vecs[9] = mk(4'b1001, 4'b1000, ENG_DONE, 0, 3,  0, 1'b0);

        repeat (3) step();
        check("rst_gnt", gnt, 0);
        check("rst_busy", busy, 0);
        check("rst_ntt_rst", ntt_rst, 1);
        check("rst_bram_owner", bram_owner, 0);
        check("rst_owner_id", owner_id, 0);
        check("rst_ntt_enable", ntt_enable, 0);
        check("rst_ntt_mode", ntt_mode, 0);
        check("rst_job_done", job_done, 0);
        check("rst_job_err", job_err, 0);
        rst = 1'b1;
        step();
        check("ntt_rst_after_release", ntt_rst, 0);

        // stray handshakes while idle must be ignored
        load_done = 1'b1; ntt_done = 1'b1; unload_done = 1'b1;
        step();
        load_done = 1'b0; ntt_done = 1'b0; unload_done = 1'b0;
        check("stray_busy", busy, 0);
        check("stray_bram_owner", bram_owner, 0);
        check("stray_ntt_enable", ntt_enable, 0);
        check("stray_job_done", job_done, 0);

        for (int i = 0; i < NVEC; i++) run_job(i, vecs[i]);

        // cancel: pointer is 1, requester 2 wins then drops during LOAD
        req = 4'b0100; req_mode = 4'b1000;
        step();
        check("cancel_gnt2", gnt, 4'b0100);
        req = 4'b1000;
        step();
        check("cancel_gnt_cleared", gnt, 0);
        check("cancel_busy", busy, 0);
        check("cancel_bram_owner", bram_owner, 0);
        check("cancel_no_enable", ntt_enable, 0);
        check("cancel_no_done", job_done, 0);
        check("cancel_no_err", job_err, 0);
        step();
        check("cancel_next_gnt3", gnt, 4'b1000);
        check("cancel_next_owner", owner_id, 3);
        $display("[TB] cancel req=0100 then owner=%0d gnt=%b", owner_id, gnt);

        // load_done and req drop together: load_done wins
        req = 4'b0000; load_done = 1'b1;
        step();
        load_done = 1'b0;
        check("tie_enable", ntt_enable, 1);
        check("tie_gnt_held", gnt, 4'b1000);
        check("tie_mode", ntt_mode, 1);
        step();
        ntt_done = 1'b1;
        step();
        ntt_done = 1'b0;
        check("tie_unload", bram_owner, 1);
        unload_done = 1'b1;
        step();
        unload_done = 1'b0;
        check("tie_job_done", job_done, 4'b1000);
        $display("[TB] tie job owner=3 job_done=%b", job_done);

        // reset during RUN: pointer is 0 here, winner 1 moves it to 2
        req = 4'b0010; req_mode = 4'b0010;
        step();
        check("pre_rst_gnt", gnt, 4'b0010);
        load_done = 1'b1;
        step();
        load_done = 1'b0;
        step();
        step();
        rst = 1'b0; req = 4'b0000;
        step();
        check("midrst_gnt", gnt, 0);
        check("midrst_busy", busy, 0);
        check("midrst_ntt_rst", ntt_rst, 1);
        check("midrst_bram_owner", bram_owner, 0);
        check("midrst_owner_id", owner_id, 0);
        check("midrst_ntt_mode", ntt_mode, 0);
        check("midrst_ntt_enable", ntt_enable, 0);
        rst = 1'b1;
        step();
        check("midrst_release_ntt_rst", ntt_rst, 0);
        check("midrst_release_gnt", gnt, 0);
        req = 4'b0110;
        step();
        check("post_rst_gnt", gnt, 4'b0010);
        check("post_rst_owner", owner_id, 1);
        $display("[TB] reset-in-run then req=0110 owner=%0d gnt=%b", owner_id, gnt);
        req = 4'b0000;
        step();
        check("post_rst_cancel", gnt, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
